dcache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between the hart's dmem port and the shared 512-bit external memory bus (ROM/RAM). It serves 32-bit word loads and stores from the CPU, fills whole 64-byte lines from external memory on a miss, and writes back dirty victims before refilling. External arbitration with the icache is outside this block.

---
 rtl/dcache_pkg.sv | 26 ++
 rtl/dcache_tagram.sv | 61 ++++++
 rtl/dcache.sv | 204 ++++++++++++++++++++
 tb/tb_dcache.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared definitions for the direct-mapped write-back data cache:
//   - line, word and offset geometry
//   - controller state encoding
//   - MMIO timer window used when DCACHE_MMIO_BYPASS_EN is defined
// -----------------------------------------------------------------------------
package dcache_pkg;

    localparam int unsigned LINE_W      = 512;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned OFFSET_BITS = 6;

    // Timer window 0x0000_C000 - 0x0000_C00F: address[31:4] == 28'h0000C00
    localparam logic [31:0] MMIO_BASE = 32'h0000_C000;
    localparam logic [31:0] MMIO_MASK = 32'hFFFF_FFF0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_FILL      = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

endpackage

// File: rtl/dcache_tagram.sv
// -----------------------------------------------------------------------------
// dcache_tagram
// Valid / dirty / tag storage for the data cache, one entry per line.
// Valid and dirty bits are cleared by the asynchronous active-low reset; the
// tag array is plain storage and is never reset.
//
// Ports:
//   clk         in   clock
//   rst         in   asynchronous active-low reset
//   i_rd_idx    in   line index for the combinational read port
//   o_rd_valid  out  valid bit of the indexed line
//   o_rd_dirty  out  dirty bit of the indexed line
//   o_rd_tag    out  tag of the indexed line
//   i_wr_en     in   write strobe (marks the line valid)
//   i_wr_idx    in   line index to write
//   i_wr_dirty  in   dirty bit to store
//   i_wr_tag    in   tag to store
// -----------------------------------------------------------------------------
module dcache_tagram
    import dcache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int TAG_W = 22
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(LINES)-1:0] i_rd_idx,
    output logic                     o_rd_valid,
    output logic                     o_rd_dirty,
    output logic [TAG_W-1:0]         o_rd_tag,
    input  logic                     i_wr_en,
    input  logic [$clog2(LINES)-1:0] i_wr_idx,
    input  logic                     i_wr_dirty,
    input  logic [TAG_W-1:0]         i_wr_tag
);

    logic [LINES-1:0] r_valid;
    logic [LINES-1:0] r_dirty;
    logic [TAG_W-1:0] r_tag [LINES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
            r_dirty[i_wr_idx] <= i_wr_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx] <= i_wr_tag;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_dirty = r_dirty[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];

endmodule

// File: rtl/dcache.sv
// -----------------------------------------------------------------------------
// dcache
// Direct-mapped, write-back, write-allocate data cache between the hart's
// dmem port and the 512-bit external memory bus. Serves 32-bit word loads and
// stores, fills whole 64-byte lines on a miss and writes dirty victims back
// before refilling.
//
// Optional feature: define DCACHE_MMIO_BYPASS_EN to make the cache ignore
// requests that fall in the timer window 0x0000_C000 - 0x0000_C00F.
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   asynchronous active-low reset
//   cpu_addr_valid  in   CPU request valid, held until cpu_data_ready
//   cpu_addr        in   byte address ([1:0] ignored)
//   cpu_data_valid  in   1 = store, 0 = load
//   cpu_data_i      in   store data
//   cpu_data_ready  out  one-cycle completion pulse
//   cpu_data_o      out  load data / merged store word during ready
//   mem_addr_valid  out  external request active
//   mem_addr        out  line address ([5:0] = 0)
//   mem_data_valid  out  external request is a line write-back
//   mem_data_o      out  write-back line data
//   mem_data_ready  in   external completion
//   mem_data_i      in   fill line data, valid with mem_data_ready
// -----------------------------------------------------------------------------
module dcache
    import dcache_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_addr_valid,
    input  logic [31:0]       cpu_addr,
    input  logic              cpu_data_valid,
    input  logic [31:0]       cpu_data_i,
    output logic              cpu_data_ready,
    output logic [31:0]       cpu_data_o,
    output logic              mem_addr_valid,
    output logic [31:0]       mem_addr,
    output logic              mem_data_valid,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_data_ready,
    input  logic [LINE_W-1:0] mem_data_i
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 32 - OFFSET_BITS - IDX_W;

    state_t              r_state;
    state_t              w_next;

    logic [31:2]         r_addr;
    logic                r_store;
    logic [WORD_W-1:0]   r_wdata;
    logic [WORD_W-1:0]   r_rdata;
    logic [LINE_W-1:0]   r_data [LINES];

    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [3:0]          w_word;
    logic                w_tv;
    logic                w_td;
    logic [TAG_W-1:0]    w_tt;
    logic                w_hit;
    logic                w_is_mmio;
    logic                w_accept;
    logic [LINE_W-1:0]   w_line;
    logic [WORD_W-1:0]   w_cur_word;
    logic                w_tag_we;
    logic                w_tag_wdirty;
    logic                w_fill_we;
    logic                w_store_hit;
    logic                w_unused_lo;

    // Word accesses only: the byte offset inside the word carries no meaning.
    assign w_unused_lo = ^cpu_addr[1:0];

`ifdef DCACHE_MMIO_BYPASS_EN
    assign w_is_mmio = ((cpu_addr & MMIO_MASK) == MMIO_BASE);
`else
    assign w_is_mmio = 1'b0;
`endif

    // A timer-window request is never latched, so the controller simply
    // stays in IDLE for as long as the CPU holds it.
    assign w_accept = (r_state == ST_IDLE) && cpu_addr_valid && !w_is_mmio;

    assign w_idx  = r_addr[OFFSET_BITS +: IDX_W];
    assign w_tag  = r_addr[31 -: TAG_W];
    assign w_word = r_addr[5:2];

    dcache_tagram #(
        .LINES (LINES),
        .TAG_W (TAG_W)
    ) u_tagram (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (w_idx),
        .o_rd_valid (w_tv),
        .o_rd_dirty (w_td),
        .o_rd_tag   (w_tt),
        .i_wr_en    (w_tag_we),
        .i_wr_idx   (w_idx),
        .i_wr_dirty (w_tag_wdirty),
        .i_wr_tag   (w_tag)
    );

    assign w_hit       = w_tv && (w_tt == w_tag);
    assign w_line      = r_data[w_idx];
    assign w_cur_word  = w_line[{w_word, 5'b0} +: WORD_W];
    assign w_store_hit = (r_state == ST_LOOKUP) && w_hit && r_store;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_tag_we       = 1'b0;
        w_tag_wdirty   = 1'b0;
        w_fill_we      = 1'b0;
        cpu_data_ready = 1'b0;
        cpu_data_o     = '0;
        mem_addr_valid = 1'b0;
        mem_data_valid = 1'b0;
        mem_addr       = '0;
        mem_data_o     = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (w_hit) begin
                    w_next = ST_DONE;
                    if (r_store) begin
                        w_tag_we     = 1'b1;
                        w_tag_wdirty = 1'b1;
                    end
                end else if (w_tv && w_td) begin
                    w_next = ST_WRITEBACK;
                end else begin
                    w_next = ST_FILL;
                end
            end
            ST_WRITEBACK: begin
                // Victim tag and data are read through the current index; nothing
                // writes this line until the write-back completes.
                mem_addr_valid = 1'b1;
                mem_data_valid = 1'b1;
                mem_addr       = {w_tt, w_idx, 6'b0};
                mem_data_o     = w_line;
                if (mem_data_ready) begin
                    w_next = ST_FILL;
                end
            end
            ST_FILL: begin
                mem_addr_valid = 1'b1;
                mem_addr       = {w_tag, w_idx, 6'b0};
                if (mem_data_ready) begin
                    w_tag_we  = 1'b1;
                    w_fill_we = 1'b1;
                    w_next    = ST_LOOKUP;
                end
            end
            ST_DONE: begin
                cpu_data_ready = 1'b1;
                cpu_data_o     = r_rdata;
                w_next         = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= cpu_addr[31:2];
            r_store <= cpu_data_valid;
            r_wdata <= cpu_data_i;
        end
        // Stores report the merged word, which is exactly the store data.
        if ((r_state == ST_LOOKUP) && w_hit) begin
            r_rdata <= r_store ? r_wdata : w_cur_word;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_data[w_idx] <= mem_data_i;
        end else if (w_store_hit) begin
            r_data[w_idx][{w_word, 5'b0} +: WORD_W] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_dcache.sv
module tb_dcache;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_addr_valid;
    logic [31:0]  cpu_addr;
    logic         cpu_data_valid;
    logic [31:0]  cpu_data_i;
    logic         cpu_data_ready;
    logic [31:0]  cpu_data_o;
    logic         mem_addr_valid;
    logic [31:0]  mem_addr;
    logic         mem_data_valid;
    logic [511:0] mem_data_o;
    logic         mem_data_ready;
    logic [511:0] mem_data_i;

    always #5 clk = ~clk;

    dcache #(.LINES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_addr_valid (cpu_addr_valid),
        .cpu_addr       (cpu_addr),
        .cpu_data_valid (cpu_data_valid),
        .cpu_data_i     (cpu_data_i),
        .cpu_data_ready (cpu_data_ready),
        .cpu_data_o     (cpu_data_o),
        .mem_addr_valid (mem_addr_valid),
        .mem_addr       (mem_addr),
        .mem_data_valid (mem_data_valid),
        .mem_data_o     (mem_data_o),
        .mem_data_ready (mem_data_ready),
        .mem_data_i     (mem_data_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: 16-line direct-mapped cache + memory
    bit           m_valid [16];
    bit           m_dirty [16];
    logic [21:0]  m_tag   [16];
    logic [511:0] m_line  [16];
    logic [511:0] bk [logic [31:0]];

    function automatic logic [511:0] pattern_line(input logic [31:0] la);
        logic [511:0] l;
        for (int w = 0; w < 16; w++) begin
            l[w*32 +: 32] = la ^ (32'(w) * 32'h0101_0101) ^ 32'h5A5A_5A5A;
        end
        return l;
    endfunction

    function automatic logic [511:0] mem_line(input logic [31:0] la);
        if (bk.exists(la)) return bk[la];
        return pattern_line(la);
    endfunction

    // ---------------- external memory responder
    logic [31:0]  wb_addr_q [$];
    logic [511:0] wb_data_q [$];
    logic [31:0]  fill_addr_q [$];
    bit           hold_fill = 1'b0;
    int           wait_cnt  = 0;

    always @(negedge clk) begin
        if (mem_data_ready) begin
            mem_data_ready = 1'b0;
        end else if (mem_addr_valid && !(hold_fill && !mem_data_valid)) begin
            if (wait_cnt == 0) begin
                if (mem_data_valid) begin
                    wb_addr_q.push_back(mem_addr);
                    wb_data_q.push_back(mem_data_o);
                end else begin
                    fill_addr_q.push_back(mem_addr);
                    mem_data_i = mem_line(mem_addr);
                end
                mem_data_ready = 1'b1;
                wait_cnt = $urandom_range(0, 3);
            end else begin
                wait_cnt--;
            end
        end
    end

    task automatic summary_and_finish();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    task automatic access(input logic [31:0] a, input bit st, input logic [31:0] d,
                          output logic [31:0] got);
        logic [3:0]   idx;
        logic [21:0]  tg;
        int           w;
        bit           hit;
        bit           exp_wb;
        logic [31:0]  exp_wb_addr;
        logic [511:0] exp_wb_data;
        logic [31:0]  exp_rd;
        int           cyc;
        idx = a[9:6];
        tg  = a[31:10];
        w   = int'(a[5:2]);
        hit = m_valid[idx] && (m_tag[idx] == tg);
        exp_wb      = !hit && m_valid[idx] && m_dirty[idx];
        exp_wb_addr = {m_tag[idx], idx, 6'b0};
        exp_wb_data = m_line[idx];
        if (exp_wb) bk[exp_wb_addr] = m_line[idx];
        if (!hit) begin
            m_line[idx]  = mem_line({tg, idx, 6'b0});
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
        end
        if (st) begin
            m_line[idx][w*32 +: 32] = d;
            m_dirty[idx] = 1'b1;
        end
        exp_rd = m_line[idx][w*32 +: 32];

        wb_addr_q.delete();
        wb_data_q.delete();
        fill_addr_q.delete();
        cpu_addr       = a;
        cpu_data_valid = st;
        cpu_data_i     = d;
        cpu_addr_valid = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!cpu_data_ready && cyc < 300);
        if (!cpu_data_ready) begin
            check("timeout_ready", 512'(cpu_data_ready), 512'(1));
            summary_and_finish();
        end
        got = cpu_data_o;
        cpu_addr_valid = 1'b0;
        check("rdata", 512'(got), 512'(exp_rd));
        if (hit) check("hit_latency", 512'(cyc), 512'(2));
        check("wb_count", 512'(wb_addr_q.size()), 512'(exp_wb));
        if (exp_wb && wb_addr_q.size() > 0) begin
            check("wb_addr", 512'(wb_addr_q[0]), 512'(exp_wb_addr));
            check("wb_data", wb_data_q[0], exp_wb_data);
        end
        check("fill_count", 512'(fill_addr_q.size()), 512'(hit ? 0 : 1));
        if (fill_addr_q.size() > 0) begin
            check("fill_addr", 512'(fill_addr_q[0]), 512'({tg, idx, 6'b0}));
        end
        @(negedge clk);
        check("ready_pulse", 512'(cpu_data_ready), 512'(0));
        check("rdata_idle", 512'(cpu_data_o), 512'(0));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, 512'(cpu_data_ready), 512'(0));
        check({tag, "_rdata"}, 512'(cpu_data_o), 512'(0));
        check({tag, "_mavalid"}, 512'(mem_addr_valid), 512'(0));
        check({tag, "_mdvalid"}, 512'(mem_data_valid), 512'(0));
        check({tag, "_maddr"}, 512'(mem_addr), 512'(0));
        check({tag, "_mdata"}, mem_data_o, 512'(0));
    endtask

    initial begin
        logic [31:0]  got;
        logic [511:0] t;
        logic [31:0]  a;
        int           cyc;

        rst = 1'b0;
        cpu_addr_valid = 1'b0;
        cpu_addr = '0;
        cpu_data_valid = 1'b0;
        cpu_data_i = '0;
        mem_data_ready = 1'b0;
        mem_data_i = '0;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
            m_line[i]  = '0;
        end
        t = pattern_line(32'h0000_8000);
        t[63:32] = 32'h1122_3344;
        bk[32'h0000_8000] = t;

        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Directed sequence
        access(32'h0000_8004, 1'b0, 32'h0, got);
        check("tp_cold_load", 512'(got), 512'(32'h1122_3344));
        access(32'h0000_8008, 1'b0, 32'h0, got);
        access(32'h0000_8008, 1'b1, 32'hDEAD_BEEF, got);
        check("tp_store_ret", 512'(got), 512'(32'hDEAD_BEEF));
        access(32'h0000_8408, 1'b0, 32'h0, got);
        if (wb_data_q.size() > 0) begin
            t = wb_data_q[0];
            check("tp_wb_word2", 512'(t[95:64]), 512'(32'hDEAD_BEEF));
        end else begin
            check("tp_wb_seen", 512'(wb_data_q.size()), 512'(1));
        end
        access(32'h0000_8008, 1'b0, 32'h0, got);
        check("tp_refill", 512'(got), 512'(32'hDEAD_BEEF));

        // Dirty line in index 1, then reset during a fill on index 0
        access(32'h0000_8048, 1'b1, 32'hCAFE_F00D, got);
        hold_fill = 1'b1;
        cpu_addr = 32'h0000_9004;
        cpu_data_valid = 1'b0;
        cpu_addr_valid = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(mem_addr_valid && !mem_data_valid) && cyc < 50);
        check("fill_reached", 512'(mem_addr_valid && !mem_data_valid), 512'(1));
        rst = 1'b0;
        cpu_addr_valid = 1'b0;
        #1;
        check_outputs_zero("rst_fill");
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        @(negedge clk);
        hold_fill = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        access(32'h0000_9004, 1'b0, 32'h0, got);
        access(32'h0000_8048, 1'b0, 32'h0, got);
        check("discard_dirty", 512'(got), 512'(32'h0000_8040 ^ 32'h0202_0202 ^ 32'h5A5A_5A5A));

        // Randomized traffic over 4 tags x 4 indices to force hits and conflicts
        for (int n = 0; n < 300; n++) begin
            a = 32'h0000_8000 | (32'($urandom_range(0, 3)) << 10)
                              | (32'($urandom_range(0, 3)) << 6)
                              | (32'($urandom_range(0, 15)) << 2)
                              | 32'($urandom_range(0, 3));
            access(a, 1'($urandom_range(0, 1)), $urandom, got);
        end

`ifdef DCACHE_MMIO_BYPASS_EN
        begin
            bit seen_ready;
            bit seen_mem;
            seen_ready = 1'b0;
            seen_mem   = 1'b0;
            cpu_addr = 32'h0000_C004;
            cpu_data_valid = 1'b0;
            cpu_addr_valid = 1'b1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                seen_ready |= cpu_data_ready;
                seen_mem   |= mem_addr_valid;
            end
            check("mmio_no_ready", 512'(seen_ready), 512'(0));
            check("mmio_no_mem", 512'(seen_mem), 512'(0));
            cpu_addr_valid = 1'b0;
            @(negedge clk);
            access(32'h0000_8004, 1'b0, 32'h0, got);
        end
`endif

        summary_and_finish();
    end

endmodule
